// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for the RV32M divide group (DIV, DIVU, REM, REMU).
// Divide-by-zero and signed overflow resolve at accept; all other operands take XLEN CALC cycles.
module div_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] src2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy,
   output logic [1:0]      dbg_state_o
);

   // Handshakes: a request transfers on a rising edge where in_valid && in_ready;
   // a result transfers on a rising edge where out_valid && out_ready. Once
   // out_valid is high, it and result stay stable until the transfer or a flush/reset.

   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] rem_q, rem_d;
   logic [XLEN-1:0] quot_q, quot_d;
   logic [XLEN-1:0] dvs_q, dvs_d;
   logic            is_rem_q, is_rem_d;
   logic            neg_q, neg_d;
   logic [XLEN-1:0] result_q, result_d;

   logic [XLEN:0]   rem_sh;
   logic [XLEN:0]   diff;
   logic            no_borrow;
   logic [XLEN-1:0] rem_step;
   logic [XLEN-1:0] quot_step;
   logic [XLEN-1:0] mag;
   logic            signed_op;
   logic            s1_neg;
   logic            s2_neg;
   logic [XLEN-1:0] a_mag;
   logic [XLEN-1:0] b_mag;
   logic            div_zero;
   logic            sgn_ovf;

   // One restoring step: the remainder gets an extra bit so divisors with the
   // top bit set still compare correctly after the shift.
   assign rem_sh    = {rem_q, quot_q[XLEN-1]};
   assign diff      = rem_sh - {1'b0, dvs_q};
   assign no_borrow = ~diff[XLEN];
   assign rem_step  = no_borrow ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
   assign quot_step = {quot_q[XLEN-2:0], no_borrow};
   assign mag       = is_rem_q ? rem_step : quot_step;

   assign signed_op = ~op[0];
   assign s1_neg    = signed_op & src1[XLEN-1];
   assign s2_neg    = signed_op & src2[XLEN-1];
   assign a_mag     = s1_neg ? -src1 : src1;
   assign b_mag     = s2_neg ? -src2 : src2;
   assign div_zero  = (src2 == '0);
   assign sgn_ovf   = signed_op && (src1 == MIN_NEG) && (src2 == '1);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      quot_d   = quot_q;
      dvs_d    = dvs_q;
      is_rem_d = is_rem_q;
      neg_d    = neg_q;
      result_d = result_q;

      if (flush) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  is_rem_d = op[1];
                  if (div_zero) begin
                     result_d = op[1] ? src1 : '1;
                     state_d  = S_DONE;
                  end else if (sgn_ovf) begin
                     result_d = op[1] ? '0 : MIN_NEG;
                     state_d  = S_DONE;
                  end else begin
                     rem_d   = '0;
                     quot_d  = a_mag;
                     dvs_d   = b_mag;
                     neg_d   = op[1] ? s1_neg : (s1_neg ^ s2_neg);
                     cnt_d   = CW'(XLEN-1);
                     state_d = S_CALC;
                  end
               end
            end
            S_CALC: begin
               rem_d  = rem_step;
               quot_d = quot_step;
               cnt_d  = cnt_q - CW'(1);
               if (cnt_q == '0) begin
                  result_d = neg_q ? -mag : mag;
                  cnt_d    = '0;
                  state_d  = S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state_d = S_IDLE;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         rem_q    <= '0;
         quot_q   <= '0;
         dvs_q    <= '0;
         is_rem_q <= 1'b0;
         neg_q    <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         quot_q   <= quot_d;
         dvs_q    <= dvs_d;
         is_rem_q <= is_rem_d;
         neg_q    <= neg_d;
         result_q <= result_d;
      end
   end

   assign in_ready    = (state_q == S_IDLE);
   assign out_valid   = (state_q == S_DONE);
   assign busy        = (state_q != S_IDLE);
   assign result      = result_q;
   assign dbg_state_o = state_q;

endmodule
